or1200_enc_seed_dispatch: RTL

- Initiator side of the seed/unstall interface into the load/store encryption FSM pair.
- Captures seed-setup operations from the decode stage into a small FIFO.
- Issues them one at a time to the encryption top as a one-cycle seed_read strobe with seed_in/seed_addr/seed_imm.
- Holds the pipeline busy until the selected path (load if seed_imm[10]=1, else store) returns unstall.

---
 rtl/or1200_enc_seed_dispatch.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/or1200_enc_seed_dispatch.sv
// ---------------------------------------------------------------------------
// or1200_enc_seed_dispatch
//
// Initiator side of the seed/unstall handshake into the load/store encryption
// FSM pair. Seed-setup operations from decode are queued in a small FIFO. They
// are issued one at a time as a single-cycle seed_read strobe carrying
// seed/address/immediate. The block then waits for the selected engine to
// return unstall: the load path when imm[10]=1, otherwise the store path.
//
// Optional build macro: OR1200_ENC_SEED_TIMEOUT_EN
//   When defined, a watchdog aborts a wait after TIMEOUT_CYC cycles and sets
//   the sticky timeout_err flag. When undefined, a wait never ends without
//   unstall and timeout_err is tied to 0.
//
// Ports
//   clk, rst         core clock, synchronous active-high reset
//   req_valid/ready  decode-side push handshake (ready = FIFO not full)
//   req_seed/addr/imm operation payload (imm[10] selects load/store path)
//   seed_read        one-cycle issue strobe toward the encryption top
//   seed_out, seed_addr_out, seed_imm_out
//                    issued payload, forced to 0 outside the strobe
//   unstall_load/store engine completion pulses
//   enc_busy         pipeline stall request (queue non-empty or dispatch active)
//   fifo_count       occupied FIFO entries
//   timeout_err      sticky watchdog flag
// ---------------------------------------------------------------------------
module or1200_enc_seed_dispatch #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned PTR_W       = 2,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_seed,
  input  logic [4:0]       req_addr,
  input  logic [10:0]      req_imm,
  output logic             seed_read,
  output logic [31:0]      seed_out,
  output logic [4:0]       seed_addr_out,
  output logic [10:0]      seed_imm_out,
  input  logic             unstall_load,
  input  logic             unstall_store,
  output logic             enc_busy,
  output logic [PTR_W:0]   fifo_count,
  output logic             timeout_err
);

  localparam int unsigned ENT_W = 48;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_LD = 2'd2,
    S_WAIT_ST = 2'd3
  } state_e;

  // FIFO storage holds payload only; it carries no reset.
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             full, push, pop;
  logic [ENT_W-1:0] head;

  state_e           state_q, state_d;

  // Issue registers: loaded on the IDLE->ISSUE transition, so the strobe and
  // payload come straight from flops and stay glitch-free toward the engines.
  logic             seed_read_q, seed_read_d;
  logic [31:0]      seed_q, seed_d;
  logic [4:0]       addr_q, addr_d;
  logic [10:0]      imm_q, imm_d;

  assign full      = (count_q == (PTR_W+1)'(DEPTH));
  assign req_ready = ~full;
  // Readiness depends only on the registered count. A pop in the same cycle
  // therefore does not let a push into a full FIFO.
  assign push      = req_valid & ~full;
  assign pop       = (state_q == S_ISSUE);
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {req_seed, req_addr, req_imm};
  end

`ifdef OR1200_ENC_SEED_TIMEOUT_EN
  localparam int unsigned TO_W =
    ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [TO_W-1:0] wcnt_q, wcnt_d;
  logic            terr_q, terr_d;
`endif

  always_comb begin
    state_d     = state_q;
    seed_read_d = 1'b0;
    seed_d      = '0;
    addr_d      = '0;
    imm_d       = '0;
`ifdef OR1200_ENC_SEED_TIMEOUT_EN
    wcnt_d      = wcnt_q;
    terr_d      = terr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d                = S_ISSUE;
          seed_read_d            = 1'b1;
          {seed_d, addr_d, imm_d} = head;
        end
      end
      S_ISSUE: begin
        // imm_q still holds the entry being issued this cycle.
        state_d = imm_q[10] ? S_WAIT_LD : S_WAIT_ST;
`ifdef OR1200_ENC_SEED_TIMEOUT_EN
        wcnt_d  = '0;
`endif
      end
      S_WAIT_LD, S_WAIT_ST: begin
        // Only the path that owns the issued operation may release the wait.
        if ((state_q == S_WAIT_LD) ? unstall_load : unstall_store) begin
          state_d = S_IDLE;
        end
`ifdef OR1200_ENC_SEED_TIMEOUT_EN
        else if (wcnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          state_d = S_IDLE;
          terr_d  = 1'b1;
        end else begin
          wcnt_d = wcnt_q + TO_W'(1);
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      seed_read_q <= 1'b0;
      seed_q      <= '0;
      addr_q      <= '0;
      imm_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      seed_read_q <= seed_read_d;
      seed_q      <= seed_d;
      addr_q      <= addr_d;
      imm_q       <= imm_d;
    end
  end

`ifdef OR1200_ENC_SEED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q <= '0;
      terr_q <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      terr_q <= terr_d;
    end
  end
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign seed_read     = seed_read_q;
  assign seed_out      = seed_q;
  assign seed_addr_out = addr_q;
  assign seed_imm_out  = imm_q;
  assign enc_busy      = (count_q != '0) | (state_q != S_IDLE);
  assign fifo_count    = count_q;

endmodule
